// File: rtl/pacman_sprite.sv
// Pacman sprite renderer: per-frame shadow latch, chomp FSM and a 2-cycle pixel pipeline.
// Optional death animation is enabled by defining PAC_DEATH_ANIM_EN.
module pacman_sprite #(
    parameter int          FRAMES_PER_PHASE = 4,
    parameter logic [23:0] PAC_COLOR        = 24'hFFFF00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  PacX,
    input  logic [9:0]  PacY,
    input  logic [9:0]  PacS,
    input  logic [1:0]  flag,
`ifdef PAC_DEATH_ANIM_EN
    input  logic        die,
    output logic        dead_done,
`endif
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        pac_on,
    output logic [23:0] pac_rgb,
    output logic [1:0]  mouth_phase
);

    localparam int CNT_W = (FRAMES_PER_PHASE > 1) ? $clog2(FRAMES_PER_PHASE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAMES_PER_PHASE - 1);

`ifdef PAC_DEATH_ANIM_EN
    typedef enum logic [2:0] {
        CLOSED = 3'b000,
        HALF_O = 3'b001,
        OPEN   = 3'b010,
        HALF_C = 3'b011,
        DYING  = 3'b100
    } state_t;
`else
    typedef enum logic [1:0] {
        CLOSED = 2'b00,
        HALF_O = 2'b01,
        OPEN   = 2'b10,
        HALF_C = 2'b11
    } state_t;
`endif

    // frame-rate state
    logic             frame_clk_q_reg;
    logic [9:0]       sx_reg, sx_next;
    logic [9:0]       sy_reg, sy_next;
    logic [9:0]       ss_reg, ss_next;
    logic [1:0]       sdir_reg, sdir_next;
    logic             moving_reg, moving_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             cnt_wrap;
    logic             fe;
    state_t           state_reg, state_next, chomp_next;
    logic [1:0]       mouth_code;

`ifdef PAC_DEATH_ANIM_EN
    logic             dead_done_reg, dead_done_next;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q_reg <= 1'b0;
            sx_reg          <= 10'd196;
            sy_reg          <= 10'd320;
            ss_reg          <= 10'd16;
            sdir_reg        <= 2'b01;
            moving_reg      <= 1'b0;
            cnt_reg         <= '0;
            state_reg       <= OPEN;
`ifdef PAC_DEATH_ANIM_EN
            dead_done_reg   <= 1'b0;
`endif
        end else begin
            frame_clk_q_reg <= frame_clk;
            sx_reg          <= sx_next;
            sy_reg          <= sy_next;
            ss_reg          <= ss_next;
            sdir_reg        <= sdir_next;
            moving_reg      <= moving_next;
            cnt_reg         <= cnt_next;
            state_reg       <= state_next;
`ifdef PAC_DEATH_ANIM_EN
            dead_done_reg   <= dead_done_next;
`endif
        end
    end

    always_comb begin
        fe          = frame_clk & ~frame_clk_q_reg;
        cnt_wrap    = (cnt_reg == CNT_MAX);
        cnt_inc     = cnt_wrap ? '0 : cnt_reg + CNT_W'(1);
        sx_next     = sx_reg;
        sy_next     = sy_reg;
        ss_next     = ss_reg;
        sdir_next   = sdir_reg;
        moving_next = moving_reg;
        cnt_next    = cnt_reg;
        state_next  = state_reg;
        case (state_reg)
            CLOSED:  chomp_next = HALF_O;
            HALF_O:  chomp_next = OPEN;
            OPEN:    chomp_next = HALF_C;
            HALF_C:  chomp_next = CLOSED;
            default: chomp_next = state_reg;
        endcase
`ifdef PAC_DEATH_ANIM_EN
        dead_done_next = dead_done_reg;
        if (state_reg == DYING) begin
            // position latch frozen; radius shrinks once per phase period
            if (fe) begin
                cnt_next = cnt_inc;
                if (cnt_wrap)
                    ss_next = (ss_reg >= 10'd2) ? ss_reg - 10'd2 : 10'd0;
            end
            if (ss_reg == 10'd0)
                dead_done_next = 1'b1;
        end else if (die) begin
            state_next = DYING;
            cnt_next   = '0;
        end else
`endif
        if (fe) begin
            sx_next     = PacX;
            sy_next     = PacY;
            ss_next     = PacS;
            sdir_next   = flag;
            moving_next = (PacX != sx_reg) || (PacY != sy_reg);
            if (moving_reg) begin
                cnt_next = cnt_inc;
                if (cnt_wrap)
                    state_next = chomp_next;
            end
        end
    end

`ifdef PAC_DEATH_ANIM_EN
    assign mouth_code = (state_reg == DYING) ? 2'b10 : state_reg[1:0];
    assign dead_done  = dead_done_reg;
`else
    assign mouth_code = state_reg;
`endif
    assign mouth_phase = mouth_code;

    // Stage 1: per-axis signed offset from the shadowed centre and its magnitude
    logic [9:0]  draw_pos   [2];
    logic [9:0]  shadow_pos [2];
    logic [10:0] delta      [2];
    logic [10:0] delta_neg  [2];
    logic [9:0]  mag        [2];

    assign draw_pos[0]   = DrawX;
    assign draw_pos[1]   = DrawY;
    assign shadow_pos[0] = sx_reg;
    assign shadow_pos[1] = sy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            assign delta[gi]     = {1'b0, draw_pos[gi]} - {1'b0, shadow_pos[gi]};
            assign delta_neg[gi] = 11'd0 - delta[gi];
            assign mag[gi]       = delta[gi][10] ? delta_neg[gi][9:0] : delta[gi][9:0];
        end
    endgenerate

    logic [10:0] fwd_next;
    logic [9:0]  lat_next;

    always_comb begin
        fwd_next = delta[0];
        lat_next = mag[1];
        case (sdir_reg)
            2'b00:   begin fwd_next = delta_neg[0]; lat_next = mag[1]; end
            2'b01:   begin fwd_next = delta[0];     lat_next = mag[1]; end
            2'b10:   begin fwd_next = delta[1];     lat_next = mag[0]; end
            default: begin fwd_next = delta_neg[1]; lat_next = mag[0]; end
        endcase
    end

    logic [9:0]  mag_reg [2];
    logic [9:0]  ss1_reg;
    logic [10:0] fwd_reg;
    logic [9:0]  lat_reg;
    logic [1:0]  mouth1_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mag_reg[0] <= '0;
            mag_reg[1] <= '0;
            ss1_reg    <= '0;
            fwd_reg    <= '0;
            lat_reg    <= '0;
            mouth1_reg <= '0;
        end else begin
            mag_reg[0] <= mag[0];
            mag_reg[1] <= mag[1];
            ss1_reg    <= ss_reg;
            fwd_reg    <= fwd_next;
            lat_reg    <= lat_next;
            mouth1_reg <= mouth_code;
        end
    end

    // Stage 2: full-width disc test and mouth wedge
    logic [19:0] sq [2];
    generate
        for (gi = 0; gi < 2; gi++) begin : g_square
            assign sq[gi] = {10'b0, mag_reg[gi]} * {10'b0, mag_reg[gi]};
        end
    endgenerate

    logic [20:0] dist_sq, rad_sq;
    logic        in_disc, fwd_pos, mask, pac_on_next;
    logic        pac_on_reg;
    logic [23:0] pac_rgb_reg;

    always_comb begin
        dist_sq = {1'b0, sq[0]} + {1'b0, sq[1]};
        rad_sq  = {1'b0, {10'b0, ss1_reg} * {10'b0, ss1_reg}};
        in_disc = (dist_sq <= rad_sq);
        fwd_pos = ~fwd_reg[10] & (fwd_reg[9:0] != 10'd0);
        case (mouth1_reg)
            2'b00:   mask = 1'b0;
            2'b10:   mask = fwd_pos & (lat_reg <= fwd_reg[9:0]);
            default: mask = fwd_pos & ({lat_reg, 1'b0} <= {1'b0, fwd_reg[9:0]});
        endcase
        pac_on_next = in_disc & ~mask;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pac_on_reg  <= 1'b0;
            pac_rgb_reg <= '0;
        end else begin
            pac_on_reg  <= pac_on_next;
            pac_rgb_reg <= pac_on_next ? PAC_COLOR : 24'h000000;
        end
    end

    assign pac_on  = pac_on_reg;
    assign pac_rgb = pac_rgb_reg;

endmodule

// File: tb/tb_pacman_sprite.sv
// Directed bench for pacman_sprite: shadow latch, mouth wedge, chomp sequence and pipeline timing.
module tb_pacman_sprite;

    logic        Clk       = 1'b0;
    logic        Reset     = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  PacX      = 10'd196;
    logic [9:0]  PacY      = 10'd320;
    logic [9:0]  PacS      = 10'd16;
    logic [1:0]  flag      = 2'b01;
    logic [9:0]  DrawX     = 10'd0;
    logic [9:0]  DrawY     = 10'd0;
    logic        pac_on;
    logic [23:0] pac_rgb;
    logic [1:0]  mouth_phase;
`ifdef PAC_DEATH_ANIM_EN
    logic        die = 1'b0;
    logic        dead_done;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pacman_sprite #(.FRAMES_PER_PHASE(4), .PAC_COLOR(24'hFFFF00)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .PacX(PacX), .PacY(PacY), .PacS(PacS), .flag(flag),
`ifdef PAC_DEATH_ANIM_EN
        .die(die), .dead_done(dead_done),
`endif
        .DrawX(DrawX), .DrawY(DrawY),
        .pac_on(pac_on), .pac_rgb(pac_rgb), .mouth_phase(mouth_phase)
    );

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1; frame_clk = 1'b0;
        @(negedge Clk);
        @(negedge Clk) Reset = 1'b0;
    endtask

    task automatic do_frame(input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] s, input logic [1:0] f);
        @(negedge Clk) PacX = x; PacY = y; PacS = s; flag = f; frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y,
                         output logic on, output logic [23:0] rgb);
        @(negedge Clk) DrawX = x; DrawY = y;
        @(posedge Clk);
        @(posedge Clk);
        #1 on = pac_on; rgb = pac_rgb;
        $display("probe (%0d,%0d) pac_on=%0b rgb=%h", x, y, on, rgb);
    endtask

    task automatic test_reset();
        int px [6];
        int py [6];
        logic ex [6];
        logic on;
        logic [23:0] rgb;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (pac_on !== 1'b0 || pac_rgb !== 24'h0) begin
            bad++; $display("FAIL reset_out pac_on=%0b rgb=%h want 0 000000", pac_on, pac_rgb);
        end
        total++;
        if (mouth_phase !== 2'b10) begin
            bad++; $display("FAIL reset_phase got=%b want=10", mouth_phase);
        end
        @(negedge Clk) Reset = 1'b0;
        // reset shadow: centre (196,320), radius 16, facing right
        px = '{196, 179, 180, 212, 196, 196};
        py = '{320, 320, 320, 320, 304, 303};
        ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            probe(10'(px[i]), 10'(py[i]), on, rgb);
            total++;
            if (on !== ex[i] || rgb !== (ex[i] ? 24'hFFFF00 : 24'h0)) begin
                bad++; $display("FAIL reset_shadow[%0d] pac_on=%0b rgb=%h want %0b", i, on, rgb, ex[i]);
            end
        end
    endtask

    task automatic test_basic();
        int px [5];
        int py [5];
        logic ex [5];
        logic on;
        logic [23:0] rgb;
        do_reset();
        do_frame(10'd196, 10'd320, 10'd16, 2'b01);
        px = '{196, 213, 196, 206, 186};
        py = '{320, 320, 336, 322, 322};
        ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            probe(10'(px[i]), 10'(py[i]), on, rgb);
            total++;
            if (on !== ex[i] || rgb !== (ex[i] ? 24'hFFFF00 : 24'h0)) begin
                bad++; $display("FAIL basic[%0d] pac_on=%0b rgb=%h want %0b", i, on, rgb, ex[i]);
            end
        end
        total++;
        if (mouth_phase !== 2'b10) begin
            bad++; $display("FAIL basic_phase got=%b want=10", mouth_phase);
        end
    endtask

    task automatic test_directions();
        logic [1:0] fl [7];
        int px [7];
        int py [7];
        logic ex [7];
        logic on;
        logic [23:0] rgb;
        do_reset();
        fl = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
        px = '{186, 207, 196, 198, 196, 196, 196};
        py = '{322, 331, 330, 330, 310, 310, 330};
        ex = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            do_frame(10'd196, 10'd320, 10'd16, fl[i]);
            probe(10'(px[i]), 10'(py[i]), on, rgb);
            total++;
            if (on !== ex[i]) begin
                bad++; $display("FAIL dir[%0d] flag=%b pac_on=%0b want %0b", i, fl[i], on, ex[i]);
            end
        end
        probe(10'd208, 10'd332, on, rgb);
        total++;
        if (on !== 1'b0) begin
            bad++; $display("FAIL disc_edge pac_on=%0b want 0", on);
        end
    endtask

    task automatic test_ss_zero();
        int px [4];
        int py [4];
        logic ex [4];
        logic on;
        logic [23:0] rgb;
        do_reset();
        do_frame(10'd100, 10'd100, 10'd0, 2'b01);
        px = '{100, 101, 99, 100};
        py = '{100, 100, 100, 101};
        ex = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            probe(10'(px[i]), 10'(py[i]), on, rgb);
            total++;
            if (on !== ex[i]) begin
                bad++; $display("FAIL ss_zero[%0d] pac_on=%0b want %0b", i, on, ex[i]);
            end
        end
    endtask

    task automatic test_chomp();
        logic [1:0] want;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            do_frame(10'd196, 10'd320, 10'd16, 2'b01);
            $display("frame idle %0d mouth_phase=%b", k, mouth_phase);
            total++;
            if (mouth_phase !== 2'b10) begin
                bad++; $display("FAIL chomp_idle[%0d] got=%b want=10", k, mouth_phase);
            end
        end
        for (int k = 1; k <= 17; k++) begin
            do_frame(10'(196 + k), 10'd320, 10'd16, 2'b01);
            if (k < 5)       want = 2'b10;
            else if (k < 9)  want = 2'b11;
            else if (k < 13) want = 2'b00;
            else if (k < 17) want = 2'b01;
            else             want = 2'b10;
            $display("frame move %0d mouth_phase=%b", k, mouth_phase);
            total++;
            if (mouth_phase !== want) begin
                bad++; $display("FAIL chomp_move[%0d] got=%b want=%b", k, mouth_phase, want);
            end
        end
    endtask

    task automatic test_half_and_reset();
        logic on;
        logic [23:0] rgb;
        do_reset();
        for (int k = 1; k <= 5; k++)
            do_frame(10'(196 + k), 10'd320, 10'd16, 2'b01);
        total++;
        if (mouth_phase !== 2'b11) begin
            bad++; $display("FAIL half_phase got=%b want=11", mouth_phase);
        end
        probe(10'd211, 10'd324, on, rgb);
        total++;
        if (on !== 1'b0) begin
            bad++; $display("FAIL half_masked pac_on=%0b want 0", on);
        end
        probe(10'd211, 10'd326, on, rgb);
        total++;
        if (on !== 1'b1) begin
            bad++; $display("FAIL half_open pac_on=%0b want 1", on);
        end
        probe(10'd201, 10'd320, on, rgb);
        total++;
        if (on !== 1'b1) begin
            bad++; $display("FAIL pre_reset pac_on=%0b want 1", on);
        end
        @(negedge Clk) Reset = 1'b1;
        @(posedge Clk);
        #1;
        $display("reset mid-frame pac_on=%0b rgb=%h mouth_phase=%b", pac_on, pac_rgb, mouth_phase);
        total++;
        if (pac_on !== 1'b0 || pac_rgb !== 24'h0) begin
            bad++; $display("FAIL reset_mid pac_on=%0b rgb=%h want 0 000000", pac_on, pac_rgb);
        end
        total++;
        if (mouth_phase !== 2'b10) begin
            bad++; $display("FAIL reset_mid_phase got=%b want=10", mouth_phase);
        end
        @(negedge Clk) Reset = 1'b0;
    endtask

    task automatic test_midframe();
        logic on, a, b;
        logic [23:0] rgb;
        do_reset();
        do_frame(10'd196, 10'd320, 10'd16, 2'b01);
        @(negedge Clk) PacX = 10'd300;
        probe(10'd196, 10'd320, on, rgb);
        total++;
        if (on !== 1'b1) begin
            bad++; $display("FAIL mid_old_centre pac_on=%0b want 1", on);
        end
        probe(10'd300, 10'd320, on, rgb);
        total++;
        if (on !== 1'b0) begin
            bad++; $display("FAIL mid_new_centre_early pac_on=%0b want 0", on);
        end
        // pixel A enters stage 1 on the same edge as the frame switch
        @(negedge Clk) DrawX = 10'd196; DrawY = 10'd320; frame_clk = 1'b1;
        @(negedge Clk) DrawX = 10'd300; frame_clk = 1'b0;
        @(posedge Clk);
        #1 a = pac_on;
        @(posedge Clk);
        #1 b = pac_on;
        $display("across frame edge old_pixel=%0b new_pixel=%0b", a, b);
        total++;
        if (a !== 1'b1) begin
            bad++; $display("FAIL inflight_old pac_on=%0b want 1", a);
        end
        total++;
        if (b !== 1'b1) begin
            bad++; $display("FAIL after_fe_new pac_on=%0b want 1", b);
        end
        probe(10'd196, 10'd320, on, rgb);
        total++;
        if (on !== 1'b0) begin
            bad++; $display("FAIL after_fe_old pac_on=%0b want 0", on);
        end
    endtask

    task automatic test_back_to_back();
        int xs [24];
        logic want;
        do_reset();
        do_frame(10'd5, 10'd320, 10'd16, 2'b00);
        for (int i = 0; i < 22; i++) xs[i] = i;
        xs[22] = 1023;
        xs[23] = 1012;
        DrawY = 10'd320;
        for (int c = 0; c <= 24; c++) begin
            @(negedge Clk) DrawX = (c < 24) ? 10'(xs[c]) : 10'd0;
            @(posedge Clk);
            #1;
            if (c >= 1) begin
                // facing left: wedge covers x<5; disc spans x=0..21 with no wrap near 1023
                want = (xs[c-1] >= 5) && (xs[c-1] <= 21);
                $display("stream x=%0d pac_on=%0b", xs[c-1], pac_on);
                total++;
                if (pac_on !== want) begin
                    bad++; $display("FAIL stream x=%0d pac_on=%0b want %0b", xs[c-1], pac_on, want);
                end
            end
        end
    endtask

`ifdef PAC_DEATH_ANIM_EN
    task automatic test_death();
        logic on;
        logic [23:0] rgb;
        do_reset();
        @(negedge Clk) die = 1'b1;
        @(negedge Clk) die = 1'b0;
        for (int k = 0; k < 31; k++)
            do_frame(10'd196, 10'd320, 10'd16, 2'b01);
        total++;
        if (dead_done !== 1'b0 || mouth_phase !== 2'b10) begin
            bad++; $display("FAIL death_early dead_done=%0b phase=%b want 0 10", dead_done, mouth_phase);
        end
        do_frame(10'd196, 10'd320, 10'd16, 2'b01);
        total++;
        if (dead_done !== 1'b1) begin
            bad++; $display("FAIL death_done dead_done=%0b want 1", dead_done);
        end
        probe(10'd196, 10'd320, on, rgb);
        total++;
        if (on !== 1'b1) begin
            bad++; $display("FAIL death_centre pac_on=%0b want 1", on);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_directions();
        test_ss_zero();
        test_chomp();
        test_half_and_reset();
        test_midframe();
        test_back_to_back();
`ifdef PAC_DEATH_ANIM_EN
        test_death();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pacman_sprite.md
Name: pacman_sprite

Overview:
- Draw-side consumer of the player movement block's outputs: position (PacX, PacY), size (PacS) and the 2-bit direction flag.
- Answers "is this pixel Pacman, and what colour" for every DrawX/DrawY from the VGA controller.
- Latches player state once per frame (tear-free) and runs a mouth-chomp animation FSM that advances only while the player is moving.
- Output feeds the colour mapper at fixed 2-cycle latency.

Parameters:
- FRAMES_PER_PHASE, 4, frame_clk rising edges per mouth phase.
- PAC_COLOR, 24'hFFFF00, RGB driven while pac_on=1.

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  vsync-derived level, synchronous to Clk; rising edge = new frame
- PacX  in  10  sprite centre X
- PacY  in  10  sprite centre Y
- PacS  in  10  sprite radius
- flag  in  2  facing direction: 00 left, 01 right, 10 down, 11 up
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- pac_on  out  1  pixel belongs to sprite, valid 2 Clk after DrawX/DrawY
- pac_rgb  out  24  PAC_COLOR when pac_on, else 0
- mouth_phase  out  2  current FSM state code (debug and scoring use)

Behaviour:
- Frame edge: fe = frame_clk & ~frame_clk_q. frame_clk_q resets to 0.
- Shadow registers: on fe, latch sx<=PacX, sy<=PacY, ss<=PacS, sdir<=flag. Reset values are sx=196, sy=320, ss=16, sdir=01. DrawX/DrawY arithmetic uses shadow values only, never the live inputs.
- Moving detect: on fe, moving<=(PacX!=sx)||(PacY!=sy), comparing live inputs against the old shadow values. Reset value 0.
- Phase counter: 0..FRAMES_PER_PHASE-1, advances on fe only when moving=1 (the value before the update). On wrap to 0, FSM steps. Counter and FSM hold when not moving. Reset value 0.
- FSM states: CLOSED(00) -> HALF_O(01) -> OPEN(10) -> HALF_C(11) -> CLOSED. Reset to OPEN(10). mouth_phase = state.
- Stage 1 (registered):
  - dx = DrawX - sx, 11-bit signed; dy = DrawY - sy, 11-bit signed.
  - Register |dx| and |dy| (10 bits each), sign bits, ss.
  - Rotate into a facing frame: fwd = signed forward distance along sdir, lat = |perpendicular| distance.
- Stage 2 (registered):
  - in_disc = |dx|^2 + |dy|^2 <= ss^2, unsigned 21-bit compare, no truncation.
  - Mouth mask by state, with fwd>0 required in every masking case:
    - CLOSED: none.
    - HALF_O or HALF_C: masked when 2*lat <= fwd.
    - OPEN: masked when lat <= fwd.
  - pac_on <= in_disc & ~mask; pac_rgb <= pac_on_next ? PAC_COLOR : 0.
- Latency is exactly 2 Clk, with no stalls and no handshake.
- Boundaries:
  - Sprite partly off-screen: signed dx/dy keep the result correct. No wrap artefacts for sx<ss.
  - ss=0: only the centre pixel is on, and only if not masked. With fwd=0 the centre is never masked.
  - fe in the same cycle as DrawX at the sprite: pixels already in the pipeline use old shadow values, so the frame switch is atomic per pixel.
  - Reset mid-frame: pipeline regs clear, pac_on=0 and pac_rgb=0 on the cycle after Reset. Shadow and FSM take their reset values.

Optional Feature:
- Macro: PAC_DEATH_ANIM_EN.
- Defined: adds input `die` (1 bit, pulse).
  - On die, enter DYING and freeze the position latch.
  - Each FRAMES_PER_PHASE frames, the effective radius decrements by 2, clamped at 0. At 0, assert output `dead_done` (1 bit) and hold until Reset.
  - The mouth is forced OPEN while DYING.
  - die while already DYING is ignored.
- Undefined: no die/dead_done ports. FSM has only the four chomp states.

Test Plan:
- Reset, then one frame with PacX=196, PacY=320, PacS=16. Expected: pixel (196,320)->pac_on=1 after 2 clk; (213,320)->0; (196,336)->1; mouth_phase=10.
- flag=01, OPEN, probe (206,322). Expected: lat=2<=fwd=10 -> masked, pac_on=0. Probe (186,322) -> pac_on=1.
- Hold PacX/PacY constant for 20 frames. Expected: mouth_phase stays 10. Then PacX +1 per frame with FRAMES_PER_PHASE=4. Expected sequence from the first moving edge: 11 after 4 edges, 00 after 8, 01 after 12, 10 after 16.
- Change PacX mid-frame, before fe. Expected: pixels still use the old centre. After fe, pixels use the new centre. Pixels in flight across fe complete with the old values.
- PacX=5, PacS=16. Probe DrawX=0..21 on row PacY. Expected: pac_on set for DrawX 0..21 minus the mouth wedge, no set pixels near X=1023.
- Assert Reset while pac_on=1. Expected: pac_on=0 and pac_rgb=0 next cycle; mouth_phase=10. With PAC_DEATH_ANIM_EN and die at PacS=16: dead_done after 8 phase periods.
